hazard_controller: RTL and testbench

- Pipeline sequencing controller in ID. Combines the forwarding unit's load-use stall (stall1) and load-jr/jalr stall (stall2) with a multi-cycle multiply/divide (MDU) busy tracker.
- Drives PC/IF-ID write enables, IF-ID and ID-EX flushes, and the HI/LO write strobe.
- Single arbitration point between data-hazard bubbles, ID-stage redirects (branch/jump) and the MDU structural hazard.

---
 rtl/hazard_controller.sv | 114 +++++++++++
 tb/tb_hazard_controller.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - ID-stage hazard arbitration with MDU busy tracking
// Optional HAZARD_PERF_EN adds stall/flush/HI-LO commit event counters.
module hazard_controller #(
   parameter int MDU_LAT = 32,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic stall1,
   input  logic stall2,
   input  logic ID_Redirect,
   input  logic ID_MduOp,
   input  logic ID_HiLoRead,
   input  logic EX_MduOp,
   output logic PC_Write,
   output logic IFID_Write,
   output logic IFID_Flush,
   output logic IDEX_Flush,
   output logic MduBusy,
   output logic HiLoWrite,
   output logic HazardStall
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] PerfStallCnt,
   output logic [31:0] PerfFlushCnt,
   output logic [31:0] PerfMduCnt
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

   localparam bit             LAT_ONE = (MDU_LAT == 1);
   localparam logic [CNT_W-1:0] RELOAD  = LAT_ONE ? '0 : CNT_W'(MDU_LAT - 2);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   mdu_state_t       state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             mdu_hazard;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // DONE accepts a new issue exactly like IDLE so back-to-back ops lose no cycle.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      case (state)
         IDLE, DONE: begin
            if (EX_MduOp) begin
               if (LAT_ONE) begin
                  state_d = DONE;
               end else begin
                  state_d = BUSY;
                  cnt_d   = RELOAD;
               end
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (cnt == '0) state_d = DONE;
            else           cnt_d   = cnt - CNT_ONE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign MduBusy   = (state != IDLE);
   assign HiLoWrite = (state == DONE);

   // DONE still counts as busy: HI/LO is only written at the end of that cycle.
   assign mdu_hazard  = MduBusy & (ID_MduOp | ID_HiLoRead);
   assign HazardStall = stall1 | stall2 | mdu_hazard;

   always_comb begin
      PC_Write   = 1'b1;
      IFID_Write = 1'b1;
      IFID_Flush = 1'b0;
      IDEX_Flush = 1'b0;
      if (HazardStall) begin
         PC_Write   = 1'b0;
         IFID_Write = 1'b0;
         IDEX_Flush = 1'b1;
      end else if (ID_Redirect) begin
         IFID_Flush = 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         PerfStallCnt <= '0;
         PerfFlushCnt <= '0;
         PerfMduCnt   <= '0;
      end else begin
         if (HazardStall) PerfStallCnt <= PerfStallCnt + 32'd1;
         if (IFID_Flush)  PerfFlushCnt <= PerfFlushCnt + 32'd1;
         if (HiLoWrite)   PerfMduCnt   <= PerfMduCnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - self-checking bench for hazard_controller
// Three instances (MDU_LAT 4, 32, 1) share ID-side inputs; HAZARD_PERF_EN optional.
module tb_hazard_controller;

   localparam int N = 3;
   localparam int LAT [N] = '{4, 32, 1};

   logic clk = 1'b0;
   logic reset;
   logic stall1, stall2, id_redirect, id_mdu_op, id_hilo_read;
   logic ex_mdu_op [N];
   logic pc_write [N];
   logic ifid_write [N];
   logic ifid_flush [N];
   logic idex_flush [N];
   logic mdu_busy [N];
   logic hilo_write [N];
   logic hazard_stall [N];
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall [N];
   logic [31:0] perf_flush [N];
   logic [31:0] perf_mdu [N];
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      hazard_controller #(.MDU_LAT(LAT[g]), .CNT_W(8)) dut (
         .clk         (clk),
         .reset       (reset),
         .stall1      (stall1),
         .stall2      (stall2),
         .ID_Redirect (id_redirect),
         .ID_MduOp    (id_mdu_op),
         .ID_HiLoRead (id_hilo_read),
         .EX_MduOp    (ex_mdu_op[g]),
         .PC_Write    (pc_write[g]),
         .IFID_Write  (ifid_write[g]),
         .IFID_Flush  (ifid_flush[g]),
         .IDEX_Flush  (idex_flush[g]),
         .MduBusy     (mdu_busy[g]),
         .HiLoWrite   (hilo_write[g]),
         .HazardStall (hazard_stall[g])
`ifdef HAZARD_PERF_EN
         ,
         .PerfStallCnt(perf_stall[g]),
         .PerfFlushCnt(perf_flush[g]),
         .PerfMduCnt  (perf_mdu[g])
`endif
      );
   end

   // An EX issue while the MDU is mid-operation (busy, not committing) is illegal.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (reset && ex_mdu_op[i] && mdu_busy[i] && !hilo_write[i]) begin
            errors++;
            $display("FAIL illegal_issue inst=%0d got=issue_while_busy exp=no_issue", i);
         end
      end
   end

   task automatic clear_inputs();
      stall1 = 0; stall2 = 0; id_redirect = 0; id_mdu_op = 0; id_hilo_read = 0;
      for (int i = 0; i < N; i++) ex_mdu_op[i] = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clear_inputs();
      repeat (2) next_cycle();
      #3;
      checks++;
      if ({pc_write[0], ifid_write[0], ifid_flush[0], idex_flush[0], mdu_busy[0], hilo_write[0], hazard_stall[0]} !== 7'b1100000) begin
         errors++;
         $display("FAIL reset_during got=%b exp=1100000", {pc_write[0], ifid_write[0], ifid_flush[0], idex_flush[0], mdu_busy[0], hilo_write[0], hazard_stall[0]});
      end
      next_cycle();
      reset = 1'b1;
      repeat (2) next_cycle();
      #3;
      for (int i = 0; i < N; i++) begin
         checks++;
         if ({pc_write[i], ifid_write[i], ifid_flush[i], idex_flush[i], mdu_busy[i], hilo_write[i], hazard_stall[i]} !== 7'b1100000) begin
            errors++;
            $display("FAIL reset_after inst=%0d got=%b exp=1100000", i, {pc_write[i], ifid_write[i], ifid_flush[i], idex_flush[i], mdu_busy[i], hilo_write[i], hazard_stall[i]});
         end
      end
   endtask

   task automatic test_load_use();
      next_cycle();
      stall1 = 1;
      #3;
      checks++;
      if ({pc_write[0], ifid_write[0], ifid_flush[0], idex_flush[0], hazard_stall[0]} !== 5'b00011) begin
         errors++;
         $display("FAIL load_use_stall got=%b exp=00011", {pc_write[0], ifid_write[0], ifid_flush[0], idex_flush[0], hazard_stall[0]});
      end
      next_cycle();
      stall1 = 0;
      #3;
      checks++;
      if ({pc_write[0], ifid_write[0], ifid_flush[0], idex_flush[0], hazard_stall[0]} !== 5'b11000) begin
         errors++;
         $display("FAIL load_use_release got=%b exp=11000", {pc_write[0], ifid_write[0], ifid_flush[0], idex_flush[0], hazard_stall[0]});
      end
   endtask

   task automatic test_stall_vs_redirect();
      next_cycle();
      stall2 = 1; id_redirect = 1;
      #3;
      checks++;
      if ({pc_write[1], ifid_flush[1], idex_flush[1]} !== 3'b001) begin
         errors++;
         $display("FAIL stall_beats_redirect got=%b exp=001", {pc_write[1], ifid_flush[1], idex_flush[1]});
      end
      next_cycle();
      stall2 = 0;
      #3;
      checks++;
      if ({pc_write[1], ifid_write[1], ifid_flush[1], idex_flush[1]} !== 4'b1110) begin
         errors++;
         $display("FAIL redirect_honoured got=%b exp=1110", {pc_write[1], ifid_write[1], ifid_flush[1], idex_flush[1]});
      end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_mdu_latency();
      bit eb, eh;
      for (int c = 0; c <= 5; c++) begin
         next_cycle();
         ex_mdu_op[0] = (c == 0);
         id_hilo_read = (c >= 1);
         #3;
         eb = (c >= 1 && c <= 4);
         eh = (c == 4);
         checks++;
         if (mdu_busy[0] !== eb) begin
            errors++;
            $display("FAIL mdu_lat_busy cycle=%0d got=%b exp=%b", c, mdu_busy[0], eb);
         end
         checks++;
         if (hilo_write[0] !== eh) begin
            errors++;
            $display("FAIL mdu_lat_hilo cycle=%0d got=%b exp=%b", c, hilo_write[0], eh);
         end
         checks++;
         if (hazard_stall[0] !== eb) begin
            errors++;
            $display("FAIL mdu_lat_stall cycle=%0d got=%b exp=%b", c, hazard_stall[0], eb);
         end
      end
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      bit eb, eh;
      for (int c = 0; c <= 9; c++) begin
         next_cycle();
         ex_mdu_op[0] = (c == 0 || c == 4);
         #3;
         eb = (c >= 1 && c <= 8);
         eh = (c == 4 || c == 8);
         checks++;
         if (mdu_busy[0] !== eb) begin
            errors++;
            $display("FAIL b2b_busy cycle=%0d got=%b exp=%b", c, mdu_busy[0], eb);
         end
         checks++;
         if (hilo_write[0] !== eh) begin
            errors++;
            $display("FAIL b2b_hilo cycle=%0d got=%b exp=%b", c, hilo_write[0], eh);
         end
      end
      clear_inputs();
   endtask

   task automatic test_lat_one();
      for (int c = 0; c <= 2; c++) begin
         next_cycle();
         ex_mdu_op[2] = (c == 0);
         #3;
         checks++;
         if ({mdu_busy[2], hilo_write[2]} !== ((c == 1) ? 2'b11 : 2'b00)) begin
            errors++;
            $display("FAIL lat1 cycle=%0d got=%b exp=%b", c, {mdu_busy[2], hilo_write[2]}, (c == 1) ? 2'b11 : 2'b00);
         end
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_op();
      for (int c = 0; c <= 10; c++) begin
         next_cycle();
         ex_mdu_op[1] = (c == 0);
         #3;
      end
      checks++;
      if (mdu_busy[1] !== 1'b1) begin
         errors++;
         $display("FAIL midop_busy_before got=%b exp=1", mdu_busy[1]);
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if (mdu_busy[1] !== 1'b0) begin
         errors++;
         $display("FAIL midop_busy_reset got=%b exp=0", mdu_busy[1]);
      end
`ifdef HAZARD_PERF_EN
      for (int i = 0; i < N; i++) begin
         checks++;
         if ({perf_stall[i], perf_flush[i], perf_mdu[i]} !== 96'd0) begin
            errors++;
            $display("FAIL perf_reset inst=%0d got=%0d/%0d/%0d exp=0/0/0", i, perf_stall[i], perf_flush[i], perf_mdu[i]);
         end
      end
`endif
      next_cycle();
      reset = 1'b1;
      for (int c = 0; c < 40; c++) begin
         next_cycle();
         #3;
         checks++;
         if ({mdu_busy[1], hilo_write[1]} !== 2'b00) begin
            errors++;
            $display("FAIL midop_after cycle=%0d got=%b exp=00", c, {mdu_busy[1], hilo_write[1]});
         end
      end
   endtask

   // Model: an accepted issue at cycle t occupies the MDU over (t, t+LAT] and commits at t+LAT.
   task automatic test_random();
      int busy_end [N];
      int n_stall [N];
      int n_flush [N];
      int n_mdu [N];
      bit eb, eh, ez, ef;
      reset = 1'b0;
      clear_inputs();
      next_cycle();
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         busy_end[i] = -1; n_stall[i] = 0; n_flush[i] = 0; n_mdu[i] = 0;
      end
      for (int c = 0; c < 600; c++) begin
         next_cycle();
         stall1       = ($urandom_range(0, 5) == 0);
         stall2       = ($urandom_range(0, 7) == 0);
         id_redirect  = ($urandom_range(0, 3) == 0);
         id_mdu_op    = ($urandom_range(0, 3) == 0);
         id_hilo_read = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < N; i++)
            ex_mdu_op[i] = (busy_end[i] <= c) && ($urandom_range(0, 2) == 0);
         #3;
         for (int i = 0; i < N; i++) begin
            eb = (busy_end[i] >= c);
            eh = (busy_end[i] == c);
            ez = stall1 | stall2 | (eb & (id_mdu_op | id_hilo_read));
            ef = !ez && id_redirect;
            checks++;
            if ({pc_write[i], ifid_write[i], ifid_flush[i], idex_flush[i], mdu_busy[i], hilo_write[i], hazard_stall[i]}
                !== {!ez, !ez, ef, ez, eb, eh, ez}) begin
               errors++;
               $display("FAIL random inst=%0d cycle=%0d got=%b exp=%b", i, c,
                  {pc_write[i], ifid_write[i], ifid_flush[i], idex_flush[i], mdu_busy[i], hilo_write[i], hazard_stall[i]},
                  {!ez, !ez, ef, ez, eb, eh, ez});
            end
`ifdef HAZARD_PERF_EN
            checks++;
            if (perf_stall[i] !== n_stall[i] || perf_flush[i] !== n_flush[i] || perf_mdu[i] !== n_mdu[i]) begin
               errors++;
               $display("FAIL perf inst=%0d cycle=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, c,
                  perf_stall[i], perf_flush[i], perf_mdu[i], n_stall[i], n_flush[i], n_mdu[i]);
            end
`endif
            n_stall[i] += int'(ez);
            n_flush[i] += int'(ef);
            n_mdu[i]   += int'(eh);
            if (ex_mdu_op[i]) busy_end[i] = c + LAT[i];
         end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_stall_vs_redirect();
      test_mdu_latency();
      test_back_to_back();
      test_lat_one();
      test_reset_mid_op();
      test_random();
      repeat (2) next_cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
